cla_addsub_bist: RTL and testbench
==================================

Name: cla_addsub_bist

Overview:
- Self-contained built-in self-test engine for the 4-bit carry-look-ahead adder/subtractor.
- Acts as the far end of the adder's interface:
  - drives A/B/Cin/control into the adder;
  - consumes sum/Cout back;
  - compares them against an internal reference model.
- Sweeps the full operand space exhaustively and reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the adder in silicon, so the arithmetic path can be checked without an external bench.

Parameters:
- WIDTH, 4: operand width; vector space N = 2^(2*WIDTH+2).
- DUT_LAT, 0: adder latency in cycles (0 = combinational, max 3); sets the expected-value delay line depth.
- ERR_W, 8: error counter width; counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; honoured only in IDLE or DONE.
- A  output  WIDTH  operand A to adder (registered).
- B  output  WIDTH  operand B to adder (registered).
- Cin  output  1  carry-in to adder (registered).
- control  output  1  0 = add, 1 = subtract (registered).
- sum  input  WIDTH  adder result.
- Cout  input  1  adder carry-out.
- busy  output  1  high during RUN and DRAIN.
- done  output  1  high in DONE; held until next start or rst.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  ERR_W  mismatches seen, saturating.
- first_fail_vec  output  2*WIDTH+2  {control,Cin,B,A} of first mismatch; 0 if none.
- first_fail_got  output  WIDTH+1  {Cout,sum} observed at first mismatch; 0 if none.

Behaviour:
- Reset (rst high on an edge):
  - state = IDLE;
  - A, B, Cin, control, busy, done, pass, err_count, first_fail_vec, first_fail_got, vector counter and delay line all = 0.
  - rst mid-run aborts immediately; no partial result is retained.
- States:
  - IDLE: start goes to RUN, clears err_count/first_fail_*, vector counter = 0.
  - RUN: drives vector k = {control,Cin,B,A} = counter; counter increments each cycle. After vector N-1 is driven: DRAIN if DUT_LAT > 0, else straight to DONE.
  - DRAIN: lasts exactly DUT_LAT cycles, compares only, then DONE.
  - DONE: done = 1, pass valid. start goes back to RUN with all results cleared.
- start while busy is ignored.
- Timing, with start sampled at edge 0:
  - vector k is on the outputs during cycle k+1;
  - its result is sampled at the edge ending cycle k+1+DUT_LAT;
  - done rises at edge N+DUT_LAT+1.
- Vector ordering: A is the LSBs, control the MSB, so all additions (vectors 0..N/2-1) precede all subtractions.
- Expected value, computed in WIDTH+1 bits:
  - control = 0: {Cout,sum} = A + B + Cin.
  - control = 1: {Cout,sum} = A + ~B + Cin (two's complement with Cin as carry-in). Example: A=10, B=10, Cin=1 gives sum=0, Cout=1.
- Delay line: expected {Cout,sum} and the vector tag are pushed through DUT_LAT register stages so each compare aligns with its own vector.
- Mismatch on any of the WIDTH+1 bits:
  - err_count increments, stopping at all-ones;
  - first_fail_* are captured only while err_count == 0 before the increment.
- No compare happens in IDLE or DONE, or in the first DUT_LAT cycles of RUN (delay-line valid bits gate it).
- A/B/Cin/control hold the last vector through DRAIN, then return to 0 in DONE.

Test Plan:
1. Correct combinational adder, WIDTH=4, DUT_LAT=0, pulse start -> busy for 1024 cycles; done at edge 1025; pass=1; err_count=0; first_fail_vec=0.
2. sum[0] forced stuck-at-0 -> first_fail_vec=10'h001, first_fail_got=5'b00000, err_count=255 (512 true failures, saturated), pass=0.
3. Cout inverted only when control=1 -> first_fail_vec=10'h200 (A=0, B=0, Cin=0, sub: expected sum=15, Cout=0); first_fail_got=5'b11111; all additions clean.
4. Adder wrapped in 2 register stages, DUT_LAT=2 -> done at edge 1027, pass=1. Same wrapper with DUT_LAT=0 -> pass=0.
5. rst asserted at cycle 300 of RUN -> next cycle: all outputs 0, state IDLE. A new start gives a full, clean 1024-vector run.
6. start pulsed at cycle 50 of RUN -> ignored (done still at edge 1025). start in DONE -> err_count/first_fail_* cleared and a new run begins.

Source files
------------

// File: rtl/cla_addsub_bist_if.sv
// Adder test port: operands and controls going out, sum and carry coming back.
// Latency: none; this is wiring only.
// Backpressure: none; the adder is free-running and is sampled at fixed cycles.
//
// Ports/signals:
//   A, B     operands (WIDTH bits)
//   Cin      carry-in
//   control  0 = add, 1 = subtract
//   sum      adder result (WIDTH bits)
//   Cout     adder carry-out
// Modports: master = BIST side (drives the operands), slave = adder side.
interface cla_addsub_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             control;
    logic [WIDTH-1:0] sum;
    logic             Cout;

    modport master (
        output A, B, Cin, control,
        input  sum, Cout
    );

    modport slave (
        input  A, B, Cin, control,
        output sum, Cout
    );
endinterface

// File: rtl/cla_addsub_bist.sv
// Exhaustive self-test sweep of a carry-look-ahead add/sub unit, checked against an internal reference.
// Latency: N + DUT_LAT + 1 cycles from the start edge to done (N = 2^(2*WIDTH+2)).
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           single-cycle run request
//   adder           master side of the adder port (A/B/Cin/control out, sum/Cout in)
//   busy            run or drain in progress (registered from state)
//   done, pass      run complete; pass = 1 iff no mismatch was seen
//   err_count       saturating mismatch count
//   first_fail_vec  {control,Cin,B,A} of the first mismatch, 0 if none
//   first_fail_got  {Cout,sum} seen at the first mismatch, 0 if none
module cla_addsub_bist #(
    parameter int WIDTH   = 4,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    cla_addsub_bist_if.master     adder,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [2*WIDTH+1:0]    first_fail_vec,
    output logic [WIDTH:0]        first_fail_got
);
    localparam int VW = 2*WIDTH + 2;
    localparam logic [VW-1:0] LAST_VEC = '1;
    // Delay-line arrays need at least one entry even when unused.
    localparam int DL = (DUT_LAT == 0) ? 1 : DUT_LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [VW-1:0]    vec;          // vector currently on the adder inputs
    logic             drv_vld;      // vec is a real test vector this cycle
    logic [1:0]       drain_cnt;

    logic [WIDTH-1:0] vec_a, vec_b, b_op;
    logic             vec_cin, vec_ctl;
    logic [WIDTH:0]   exp_now;
    logic [WIDTH:0]   got;

    logic             cmp_vld;
    logic [WIDTH:0]   cmp_exp;
    logic [VW-1:0]    cmp_tag;
    logic             cmp_en;
    logic             mismatch;

    // Vector layout puts A in the LSBs and control in the MSB, so a plain
    // binary count runs every addition before any subtraction.
    assign vec_a   = vec[WIDTH-1:0];
    assign vec_b   = vec[2*WIDTH-1:WIDTH];
    assign vec_cin = vec[2*WIDTH];
    assign vec_ctl = vec[2*WIDTH+1];

    assign adder.A       = vec_a;
    assign adder.B       = vec_b;
    assign adder.Cin     = vec_cin;
    assign adder.control = vec_ctl;

    // Reference: subtraction is A + ~B + Cin, Cin acting as the +1 of two's complement.
    assign b_op    = vec_ctl ? ~vec_b : vec_b;
    assign exp_now = {1'b0, vec_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, vec_cin};
    assign got     = {adder.Cout, adder.sum};

    // Expected value and tag travel alongside the adder pipeline so each
    // compare lines up with the vector that produced it.
    generate
        if (DUT_LAT == 0) begin : g_nodelay
            assign cmp_vld = drv_vld;
            assign cmp_exp = exp_now;
            assign cmp_tag = vec;
        end else begin : g_delay
            logic           dl_vld [DL];
            logic [WIDTH:0] dl_exp [DL];
            logic [VW-1:0]  dl_tag [DL];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DL; i++) begin
                        dl_vld[i] <= 1'b0;
                        dl_exp[i] <= '0;
                        dl_tag[i] <= '0;
                    end
                end else begin
                    dl_vld[0] <= drv_vld;
                    dl_exp[0] <= exp_now;
                    dl_tag[0] <= vec;
                    for (int i = 1; i < DL; i++) begin
                        dl_vld[i] <= dl_vld[i-1];
                        dl_exp[i] <= dl_exp[i-1];
                        dl_tag[i] <= dl_tag[i-1];
                    end
                end
            end

            assign cmp_vld = dl_vld[DL-1];
            assign cmp_exp = dl_exp[DL-1];
            assign cmp_tag = dl_tag[DL-1];
        end
    endgenerate

    assign cmp_en   = cmp_vld && (state == RUN || state == DRAIN);
    assign mismatch = cmp_en && (got != cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (vec == LAST_VEC) state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
            DRAIN: if (drain_cnt == 2'(DUT_LAT - 1)) state_nxt = DONE;
            DONE:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec            <= '0;
            drv_vld        <= 1'b0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_got <= '0;
        end else begin
            // Status flags lag the state by one edge, so done rises only
            // after the final compare has landed in err_count.
            busy <= (state == RUN) || (state == DRAIN);
            done <= (state == DONE) && !start;
            pass <= (state == DONE) && !start && (err_count == '0);

            if (mismatch) begin
                if (err_count == '0) begin
                    first_fail_vec <= cmp_tag;
                    first_fail_got <= got;
                end
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec            <= '0;
                        drv_vld        <= 1'b1;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        first_fail_got <= '0;
                    end
                end
                RUN: begin
                    if (vec == LAST_VEC) begin
                        drv_vld   <= 1'b0;
                        drain_cnt <= '0;
                        // Last vector is held through DRAIN; cleared on DONE entry.
                        if (DUT_LAT == 0) vec <= '0;
                    end else begin
                        vec <= vec + VW'(1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'(DUT_LAT - 1)) vec <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_addsub_bist.sv
module tb_cla_addsub_bist;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    // Fault selection for the adder beside dut0:
    // 0 clean, 1 result bit stuck at 0, 2 Cout inverted on subtract, 3 two register stages
    int mode = 0;
    int sbit = 0;
    int sel  = 0;

    int n_chk  = 0;
    int n_fail = 0;

    cla_addsub_bist_if #(.WIDTH(4)) bus0 ();
    cla_addsub_bist_if #(.WIDTH(4)) bus1 ();

    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0, err1;
    logic [9:0] ffv0, ffv1;
    logic [4:0] ffg0, ffg1;

    cla_addsub_bist #(.WIDTH(4), .DUT_LAT(0), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .adder(bus0.master),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_got(ffg0)
    );

    cla_addsub_bist #(.WIDTH(4), .DUT_LAT(2), .ERR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .adder(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_got(ffg1)
    );

    // Arithmetic reference: {Cout,sum} of the vector, subtraction as A + (15-B) + Cin.
    function automatic logic [4:0] ideal(input logic [9:0] v);
        int a, b, c, r;
        a = int'(v[3:0]);
        b = int'(v[7:4]);
        c = int'(v[8]);
        if (v[9]) r = (a + (15 - b) + c) % 32;
        else      r = (a + b + c) % 32;
        return 5'(r);
    endfunction

    function automatic logic [4:0] faulty(input logic [9:0] v, input int m, input int bt);
        logic [4:0] r;
        r = ideal(v);
        if (m == 1) r[bt] = 1'b0;
        if (m == 2 && v[9]) r[4] = ~r[4];
        return r;
    endfunction

    // Adder models driving back into the BIST engines.
    logic [9:0] v0, v1;
    logic [4:0] d1, d2, e1, e2, res0;
    assign v0 = {bus0.control, bus0.Cin, bus0.B, bus0.A};
    assign v1 = {bus1.control, bus1.Cin, bus1.B, bus1.A};

    always_ff @(posedge clk) begin
        d1 <= ideal(v0);
        d2 <= d1;
        e1 <= ideal(v1);
        e2 <= e1;
    end

    always_comb begin
        res0 = faulty(v0, mode, sbit);
        if (mode == 3) res0 = d2;
    end

    assign bus0.sum  = res0[3:0];
    assign bus0.Cout = res0[4];
    assign bus1.sum  = e2[3:0];
    assign bus1.Cout = e2[4];

    // Observation mux for whichever engine is under test.
    logic       m_busy, m_done, m_pass;
    logic [7:0] m_err;
    logic [9:0] m_ffv, m_vec;
    logic [4:0] m_ffg;
    always_comb begin
        m_busy = busy0; m_done = done0; m_pass = pass0; m_err = err0;
        m_ffv = ffv0; m_ffg = ffg0; m_vec = v0;
        if (sel == 1) begin
            m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1;
            m_ffv = ffv1; m_ffg = ffg1; m_vec = v1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else            start1 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the whole operand space through the faulty adder and collect
    // what the engine should report.
    task automatic model_expect(input int m, input int bt, output int errs,
                                output int ffv, output int ffg);
        int cnt;
        logic [9:0] v;
        logic [4:0] g;
        cnt = 0; ffv = 0; ffg = 0;
        for (int k = 0; k < 1024; k++) begin
            v = 10'(k);
            g = faulty(v, m, bt);
            if (g != ideal(v)) begin
                if (cnt == 0) begin
                    ffv = k;
                    ffg = int'(g);
                end
                cnt++;
            end
        end
        errs = (cnt > 255) ? 255 : cnt;
    endtask

    // One full run: start pulse, optional stray start mid-run, timing and
    // vector-sequence checks, bounded wait for done.
    task automatic run(input int which, input int lat, input string tag, input int mid_start);
        int n, nbusy, verr;
        bit fin;
        sel = which;
        tick();
        set_start(which, 1'b1);
        tick();                       // edge 0
        set_start(which, 1'b0);
        chk({tag, "_clr_err"}, int'(m_err), 0);
        chk({tag, "_clr_ffv"}, int'(m_ffv), 0);
        chk({tag, "_vec0"}, int'(m_vec), 0);
        n = 0; nbusy = 0; verr = 0; fin = 0;
        while (!fin && n < 1200) begin
            tick();
            n++;
            if (n == mid_start)          set_start(which, 1'b1);
            else if (n == mid_start + 1) set_start(which, 1'b0);
            if (m_busy) nbusy++;
            if (n < 1024 && m_vec != 10'(n)) verr++;
            if (m_done) fin = 1;
        end
        set_start(which, 1'b0);
        chk({tag, "_done_edge"}, n, 1025 + lat);
        chk({tag, "_busy_cycles"}, nbusy, 1024 + lat);
        chk({tag, "_vec_seq_errs"}, verr, 0);
        chk({tag, "_vec_idle"}, int'(m_vec), 0);
    endtask

    task automatic check_results(input string tag, input int errs, input int ffv, input int ffg);
        chk({tag, "_err_count"}, int'(m_err), errs);
        chk({tag, "_first_vec"}, int'(m_ffv), ffv);
        chk({tag, "_first_got"}, int'(m_ffg), ffg);
        chk({tag, "_pass"}, int'(m_pass), (errs == 0) ? 1 : 0);
        chk({tag, "_done"}, int'(m_done), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(m_busy), 0);
        chk({tag, "_done"}, int'(m_done), 0);
        chk({tag, "_pass"}, int'(m_pass), 0);
        chk({tag, "_err"}, int'(m_err), 0);
        chk({tag, "_ffv"}, int'(m_ffv), 0);
        chk({tag, "_ffg"}, int'(m_ffg), 0);
        chk({tag, "_vec"}, int'(m_vec), 0);
    endtask

    initial begin
        int e, fv, fg, rst_at;

        repeat (3) tick();
        sel = 0;
        check_zero("reset0");
        sel = 1;
        check_zero("reset1");
        rst = 1'b0;

        // Clean run with a stray start somewhere inside RUN.
        mode = 0;
        run(0, 0, "clean", int'($urandom_range(10, 1000)));
        model_expect(0, 0, e, fv, fg);
        check_results("clean", e, fv, fg);

        // Start from DONE with sum[0] stuck at 0.
        mode = 1; sbit = 0;
        run(0, 0, "stuck0", -10);
        model_expect(1, 0, e, fv, fg);
        check_results("stuck0", e, fv, fg);

        // Carry-out inverted on subtract only.
        mode = 2;
        run(0, 0, "subcout", -10);
        model_expect(2, 0, e, fv, fg);
        check_results("subcout", e, fv, fg);

        // A randomly chosen result bit stuck at 0.
        mode = 1; sbit = int'($urandom_range(1, 4));
        run(0, 0, "stuckr", -10);
        model_expect(1, sbit, e, fv, fg);
        check_results("stuckr", e, fv, fg);

        // Pipelined adder seen through a zero-latency checker must fail.
        mode = 3;
        run(0, 0, "latmis", -10);
        chk("latmis_pass", int'(m_pass), 0);
        chk("latmis_err_nonzero", int'(m_err != 8'd0), 1);

        // Pipelined adder with matching checker latency.
        run(1, 2, "lat2", -10);
        check_results("lat2", 0, 0, 0);

        // Reset in the middle of a failing run, then a fresh clean run.
        mode = 1; sbit = 0;
        sel = 0;
        rst_at = int'($urandom_range(280, 320));
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (rst_at) tick();
        chk("pre_rst_err_nonzero", int'(m_err != 8'd0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        repeat (5) tick();
        check_zero("midrst_idle");
        mode = 0;
        run(0, 0, "after_rst", -10);
        check_results("after_rst", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
